// File: rtl/ram_arbiter_pkg.sv
// ram_arb_pkg: shared types and constants for the two-requester RAM arbiter.
//   state_e      : sequencer states IDLE -> ACCESS -> RESP
//   req_id_t     : requester id (0 = fetch side, 1 = load/store side)
//   ADDR_W_DEF / DATA_W_DEF : default RAM geometry (64 x 16)
//   REGBANK_BASE : first address of the register bank A/B/C/D (60..63)
package ram_arb_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 16;

  localparam logic [5:0] REGBANK_BASE = 6'd60;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef logic req_id_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundle of both requester handshakes and the RAM bus.
//   slave  modport : the arbiter's view (requests and ram_data_out in,
//                    readies, responses and RAM controls out)
//   master modport : the view of the requesters and the RAM instance
interface ram_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              req0_valid;
  logic              req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_rdata;

  logic              req1_valid;
  logic              req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_rdata;
  logic              rsp1_err;

  logic              ram_write;
  logic              ram_read;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data_in;
  logic [DATA_W-1:0] ram_data_out;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    output req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    output ram_write, ram_read, ram_addr, ram_data_in,
    input  ram_data_out
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    input  ram_write, ram_read, ram_addr, ram_data_in,
    output ram_data_out
  );

endinterface

// File: rtl/ram_arbiter_rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin grant.
//   valid0_i, valid1_i : request lines
//   last_grant_i       : id of the previously granted requester
//   grant_o[1:0]       : one-hot grant (all-zero when nobody is valid)
module rr_arbiter2
  import ram_arb_pkg::*;
(
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  req_id_t    last_grant_i,
  output logic [1:0] grant_o
);

  // Under contention the requester that did not win last time goes first.
  assign grant_o[0] = valid0_i & (~valid1_i | (last_grant_i == 1'b1));
  assign grant_o[1] = valid1_i & (~valid0_i | (last_grant_i == 1'b0));

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: serialises fetch (0) and load/store (1) requests onto the
// 64x16 single-port data RAM. Each transaction takes three cycles:
// IDLE (handshake) -> ACCESS (RAM strobe) -> RESP (one-cycle response).
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ram_arbiter_if.slave carrying both requester handshakes
//           (reqN_valid/we/addr/wdata/ready, rspN_valid/rdata, rsp1_err)
//           and the RAM bus (ram_write/read/addr/data_in, ram_data_out)
// Optional build macro RAM_ARB_REGBANK_PROTECT_EN: requester-1 writes to the
// register bank (addresses 60..63) are dropped and answered with rsp1_err=1.
// Without it every write proceeds and rsp1_err is constant 0.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_arbiter_if.slave  bus
);

  localparam logic [ADDR_W-1:0] RB_BASE = ADDR_W'(REGBANK_BASE);

  state_e            state_q;
  req_id_t           last_grant_q;
  req_id_t           txn_id_q;
  logic              txn_we_q;

  logic              ram_write_q;
  logic              ram_read_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_data_in_q;

  logic              rsp0_valid_q;
  logic              rsp1_valid_q;
  logic [DATA_W-1:0] rsp0_rdata_q;
  logic [DATA_W-1:0] rsp1_rdata_q;

  logic [1:0]        grant;
  req_id_t           sel_id_d;
  logic              sel_we_d;
  logic [ADDR_W-1:0] sel_addr_d;
  logic [DATA_W-1:0] sel_wdata_d;
  logic              wr_allow_d;
  logic [DATA_W-1:0] rdata_d;

`ifdef RAM_ARB_REGBANK_PROTECT_EN
  logic              txn_rej_q;
  logic              rsp1_err_q;
`endif

  rr_arbiter2 u_rr (
    .valid0_i     (bus.req0_valid),
    .valid1_i     (bus.req1_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  // Ready is combinational so a requester sees acceptance in the same cycle;
  // gated by rst_n so it stays low while reset is held.
  assign bus.req0_ready = rst_n & (state_q == IDLE) & grant[0];
  assign bus.req1_ready = rst_n & (state_q == IDLE) & grant[1];

  // Request fields of the current winner.
  always_comb begin
    sel_id_d    = 1'b0;
    sel_we_d    = bus.req0_we;
    sel_addr_d  = bus.req0_addr;
    sel_wdata_d = bus.req0_wdata;
    if (grant[1]) begin
      sel_id_d    = 1'b1;
      sel_we_d    = bus.req1_we;
      sel_addr_d  = bus.req1_addr;
      sel_wdata_d = bus.req1_wdata;
    end
  end

`ifdef RAM_ARB_REGBANK_PROTECT_EN
  assign wr_allow_d = ~((sel_id_d == 1'b1) && (sel_addr_d >= RB_BASE));
`else
  assign wr_allow_d = 1'b1;
`endif

  // Writes answer with zero data; reads pass the async RAM output through.
  assign rdata_d = txn_we_q ? '0 : bus.ram_data_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      txn_id_q      <= 1'b0;
      txn_we_q      <= 1'b0;
      ram_write_q   <= 1'b0;
      ram_read_q    <= 1'b0;
      ram_addr_q    <= '0;
      ram_data_in_q <= '0;
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp0_rdata_q  <= '0;
      rsp1_rdata_q  <= '0;
`ifdef RAM_ARB_REGBANK_PROTECT_EN
      txn_rej_q     <= 1'b0;
      rsp1_err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (|grant) begin
            txn_id_q      <= sel_id_d;
            txn_we_q      <= sel_we_d;
            last_grant_q  <= sel_id_d;
            ram_addr_q    <= sel_addr_d;
            ram_data_in_q <= sel_wdata_d;
            // Strobes are registered so they are high for exactly ACCESS.
            ram_write_q   <= sel_we_d & wr_allow_d;
            ram_read_q    <= ~sel_we_d;
`ifdef RAM_ARB_REGBANK_PROTECT_EN
            txn_rej_q     <= sel_we_d & ~wr_allow_d;
`endif
            state_q       <= ACCESS;
          end
        end
        ACCESS: begin
          ram_write_q <= 1'b0;
          ram_read_q  <= 1'b0;
          if (txn_id_q == 1'b0) begin
            rsp0_valid_q <= 1'b1;
            rsp0_rdata_q <= rdata_d;
          end else begin
            rsp1_valid_q <= 1'b1;
            rsp1_rdata_q <= rdata_d;
`ifdef RAM_ARB_REGBANK_PROTECT_EN
            rsp1_err_q   <= txn_rej_q;
`endif
          end
          state_q <= RESP;
        end
        RESP: begin
          rsp0_valid_q <= 1'b0;
          rsp1_valid_q <= 1'b0;
`ifdef RAM_ARB_REGBANK_PROTECT_EN
          rsp1_err_q   <= 1'b0;
`endif
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ram_write   = ram_write_q;
  assign bus.ram_read    = ram_read_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_data_in = ram_data_in_q;
  assign bus.rsp0_valid  = rsp0_valid_q;
  assign bus.rsp0_rdata  = rsp0_rdata_q;
  assign bus.rsp1_valid  = rsp1_valid_q;
  assign bus.rsp1_rdata  = rsp1_rdata_q;
`ifdef RAM_ARB_REGBANK_PROTECT_EN
  assign bus.rsp1_err    = rsp1_err_q;
`else
  assign bus.rsp1_err    = 1'b0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: table of single transactions plus hand-written
// sequences for reset, contention, reset mid-access, register-bank
// protection and back-to-back requests. Includes a 64x16 async-read RAM.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  logic clk;
  logic rst_n;

  ram_arbiter_if #(.ADDR_W(6), .DATA_W(16)) bus ();

  ram_arbiter #(.ADDR_W(6), .DATA_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: initial contents A000+addr, write commits at rising edge.
  logic [15:0] mem [64];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'hA000 + 16'(i);
  end
  always @(posedge clk) begin
    if (bus.ram_write) mem[bus.ram_addr] <= bus.ram_data_in;
  end
  assign bus.ram_data_out = mem[bus.ram_addr];

  int checks;
  int errors;

  typedef struct {
    logic        v0;
    logic        we0;
    logic [5:0]  a0;
    logic [15:0] d0;
    logic        v1;
    logic        we1;
    logic [5:0]  a1;
    logic [15:0] d1;
    logic        exp_id;
    logic        exp_wr;
    logic        exp_rd;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  function automatic vec_t mk(input logic v0, input logic we0, input logic [5:0] a0,
                              input logic [15:0] d0, input logic v1, input logic we1,
                              input logic [5:0] a1, input logic [15:0] d1,
                              input logic id, input logic wr, input logic rd,
                              input logic [15:0] rdata, input logic err);
    vec_t v;
    v.v0 = v0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
    v.exp_id = id; v.exp_wr = wr; v.exp_rd = rd;
    v.exp_rdata = rdata; v.exp_err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_we = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
    bus.req1_valid = 1'b0; bus.req1_we = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
  endtask

  // Runs one transaction starting just after a rising edge with the DUT in
  // IDLE; returns just after the edge that brings it back to IDLE.
  task automatic do_txn(input vec_t v, input string tag);
    logic [5:0]  exp_addr;
    logic [15:0] exp_wd;
    exp_addr = v.exp_id ? v.a1 : v.a0;
    exp_wd   = v.exp_id ? v.d1 : v.d0;
    bus.req0_valid = v.v0; bus.req0_we = v.we0; bus.req0_addr = v.a0; bus.req0_wdata = v.d0;
    bus.req1_valid = v.v1; bus.req1_we = v.we1; bus.req1_addr = v.a1; bus.req1_wdata = v.d1;
    @(negedge clk);
    chk({tag, ".ready0"}, bus.req0_ready, v.exp_id == 1'b0);
    chk({tag, ".ready1"}, bus.req1_ready, v.exp_id == 1'b1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(negedge clk);
    chk({tag, ".ram_write"}, bus.ram_write, v.exp_wr);
    chk({tag, ".ram_read"}, bus.ram_read, v.exp_rd);
    chk({tag, ".ram_addr"}, bus.ram_addr, exp_addr);
    if (v.exp_wr) chk({tag, ".ram_data_in"}, bus.ram_data_in, exp_wd);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, ".rsp0_valid"}, bus.rsp0_valid, v.exp_id == 1'b0);
    chk({tag, ".rsp1_valid"}, bus.rsp1_valid, v.exp_id == 1'b1);
    chk({tag, ".rdata"}, v.exp_id ? bus.rsp1_rdata : bus.rsp0_rdata, v.exp_rdata);
    chk({tag, ".rsp1_err"}, bus.rsp1_err, v.exp_err);
    chk({tag, ".strobes_off"}, {bus.ram_write, bus.ram_read}, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, ".rsp_pulse_end"}, {bus.rsp0_valid, bus.rsp1_valid}, 2'b00);
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".readies"}, {bus.req0_ready, bus.req1_ready}, 2'b00);
    chk({tag, ".rsp_valids"}, {bus.rsp0_valid, bus.rsp1_valid, bus.rsp1_err}, 3'b000);
    chk({tag, ".strobes"}, {bus.ram_write, bus.ram_read}, 2'b00);
    chk({tag, ".ram_addr"}, bus.ram_addr, 6'd0);
    chk({tag, ".ram_data_in"}, bus.ram_data_in, 16'd0);
    chk({tag, ".rdata"}, {bus.rsp0_rdata, bus.rsp1_rdata}, 32'd0);
  endtask

  vec_t tbl [9];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;

    tbl[0] = mk(1, 1, 6'd5,  16'hBEEF, 1, 0, 6'd7,  16'h0000, 0, 1, 0, 16'h0000, 0);
    tbl[1] = mk(1, 0, 6'd5,  16'h0000, 0, 0, 6'd0,  16'h0000, 0, 0, 1, 16'hBEEF, 0);
    tbl[2] = mk(1, 0, 6'd5,  16'h0000, 1, 0, 6'd7,  16'h0000, 1, 0, 1, 16'hA007, 0);
    tbl[3] = mk(0, 0, 6'd0,  16'h0000, 1, 1, 6'd8,  16'h1111, 1, 1, 0, 16'h0000, 0);
    tbl[4] = mk(0, 0, 6'd0,  16'h0000, 1, 0, 6'd8,  16'h0000, 1, 0, 1, 16'h1111, 0);
    tbl[5] = mk(1, 0, 6'd63, 16'h0000, 1, 1, 6'd20, 16'h5555, 0, 0, 1, 16'hA03F, 0);
    tbl[6] = mk(1, 1, 6'd20, 16'h7777, 1, 0, 6'd20, 16'h0000, 1, 0, 1, 16'hA014, 0);
    tbl[7] = mk(1, 1, 6'd20, 16'h7777, 0, 0, 6'd0,  16'h0000, 0, 1, 0, 16'h0000, 0);
    tbl[8] = mk(0, 0, 6'd0,  16'h0000, 1, 0, 6'd20, 16'h0000, 1, 0, 1, 16'h7777, 0);

    // Reset held with random inputs.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.req0_valid = 1'($urandom); bus.req0_we = 1'($urandom);
      bus.req0_addr = 6'($urandom); bus.req0_wdata = 16'($urandom);
      bus.req1_valid = 1'($urandom); bus.req1_we = 1'($urandom);
      bus.req1_addr = 6'($urandom); bus.req1_wdata = 16'($urandom);
      @(negedge clk);
      chk_all_zero("reset");
    end
    idle_inputs();
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) do_txn(tbl[i], $sformatf("vec%0d", i));

    // Contention: both continuously valid, reads of addr 0 / addr 1.
    bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 6'd0;
    bus.req1_valid = 1'b1; bus.req1_we = 1'b0; bus.req1_addr = 6'd1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("rr%0d.ready0", k), bus.req0_ready, (k % 2) == 0);
      chk($sformatf("rr%0d.ready1", k), bus.req1_ready, (k % 2) == 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("rr%0d.acc_ready", k), {bus.req0_ready, bus.req1_ready}, 2'b00);
      chk($sformatf("rr%0d.strobes", k), {bus.ram_write, bus.ram_read}, 2'b01);
      chk($sformatf("rr%0d.addr", k), bus.ram_addr, 6'(k % 2));
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("rr%0d.rspv", k), {bus.rsp1_valid, bus.rsp0_valid},
          ((k % 2) == 0) ? 2'b01 : 2'b10);
      chk($sformatf("rr%0d.rdata", k),
          ((k % 2) == 0) ? bus.rsp0_rdata : bus.rsp1_rdata, 16'hA000 + 16'(k % 2));
      chk($sformatf("rr%0d.resp_strobes", k), {bus.ram_write, bus.ram_read}, 2'b00);
      @(posedge clk); #1;
    end
    idle_inputs();

    // Reset during ACCESS of a req1 write to addr 10.
    bus.req1_valid = 1'b1; bus.req1_we = 1'b1; bus.req1_addr = 6'd10; bus.req1_wdata = 16'h1234;
    @(negedge clk);
    chk("midrst.ready1", bus.req1_ready, 1'b1);
    @(posedge clk); #1;
    idle_inputs();
    chk("midrst.access_write", bus.ram_write, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk); #1;
    chk("midrst.no_rsp_a", bus.rsp1_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst.no_rsp_b", bus.rsp1_valid, 1'b0);
    @(posedge clk); #1;
    do_txn(mk(1, 0, 6'd10, 16'h0, 0, 0, 6'd0, 16'h0, 0, 0, 1, 16'hA00A, 0), "midrst_rd");

    // Register-bank write from requester 1.
`ifdef RAM_ARB_REGBANK_PROTECT_EN
    do_txn(mk(0, 0, 6'd0, 16'h0, 1, 1, 6'd63, 16'h00FF, 1, 0, 0, 16'h0000, 1), "prot_wr1");
    do_txn(mk(0, 0, 6'd0, 16'h0, 1, 0, 6'd63, 16'h0000, 1, 0, 1, 16'hA03F, 0), "prot_rd1");
`else
    do_txn(mk(0, 0, 6'd0, 16'h0, 1, 1, 6'd63, 16'h00FF, 1, 1, 0, 16'h0000, 0), "prot_wr1");
    do_txn(mk(0, 0, 6'd0, 16'h0, 1, 0, 6'd63, 16'h0000, 1, 0, 1, 16'h00FF, 0), "prot_rd1");
`endif
    do_txn(mk(1, 1, 6'd63, 16'h0ABC, 0, 0, 6'd0, 16'h0, 0, 1, 0, 16'h0000, 0), "prot_wr0");
    do_txn(mk(1, 0, 6'd63, 16'h0000, 0, 0, 6'd0, 16'h0, 0, 0, 1, 16'h0ABC, 0), "prot_rd0");

    // Requester 1 alone, held valid, reading addr 0..3 back to back.
    bus.req1_valid = 1'b1; bus.req1_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.req1_addr = 6'(k);
      @(negedge clk);
      chk($sformatf("b2b%0d.ready1", k), bus.req1_ready, 1'b1);
      chk($sformatf("b2b%0d.ready0", k), bus.req0_ready, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("b2b%0d.busy", k), {bus.req0_ready, bus.req1_ready}, 2'b00);
      chk($sformatf("b2b%0d.addr", k), bus.ram_addr, 6'(k));
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("b2b%0d.busy2", k), {bus.req0_ready, bus.req1_ready}, 2'b00);
      chk($sformatf("b2b%0d.rspv", k), bus.rsp1_valid, 1'b1);
      chk($sformatf("b2b%0d.rdata", k), bus.rsp1_rdata, 16'hA000 + 16'(k));
      @(posedge clk); #1;
    end
    idle_inputs();
    @(negedge clk);
    chk("hold.rsp0_rdata", bus.rsp0_rdata, 16'h0ABC);
    chk("hold.rsp1_rdata", bus.rsp1_rdata, 16'hA003);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester arbiter/sequencer for the 64x16 single-port data RAM.
- Requester 0 is the instruction/fetch side; requester 1 is the load/store side.
- Serialises requests with a round-robin policy, drives the RAM's write/read/addr/data_in, captures async read data into a register and returns a one-cycle response pulse per transaction.
- Sits between the CPU control unit and the RAM instance.

Parameters:
- ADDR_W, 6, RAM address width (64 words).
- DATA_W, 16, RAM data width.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has a request
- req0_we  input  1  1 = write, 0 = read
- req0_addr  input  ADDR_W  word address
- req0_wdata  input  DATA_W  write data
- req0_ready  output  1  request 0 accepted this cycle
- rsp0_valid  output  1  one-cycle response pulse to requester 0
- rsp0_rdata  output  DATA_W  read data for requester 0
- req1_valid / req1_we / req1_addr / req1_wdata / req1_ready / rsp1_valid / rsp1_rdata: same as requester 0, for requester 1
- rsp1_err  output  1  protected-write rejection flag, valid with rsp1_valid
- ram_write  output  1  to RAM write
- ram_read  output  1  to RAM read
- ram_addr  output  ADDR_W  to RAM addr
- ram_data_in  output  DATA_W  to RAM data_in
- ram_data_out  input  DATA_W  from RAM data_out (async read)

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous, active-low.
- Reset values:
  - state=IDLE, last_grant=1 (so requester 0 wins first).
  - All outputs 0: readies, rsp valids, rdata, rsp1_err, ram_write, ram_read, ram_addr, ram_data_in.
- FSM IDLE:
  - reqN_ready = 1 only for the arbitration winner; it is combinational from valids and last_grant.
  - Arbitration: only one valid wins. Both valid wins the requester != last_grant.
  - On handshake (valid & ready at the edge):
    - latch id, we, addr, wdata into txn registers;
    - last_grant <= id;
    - go to ACCESS.
  - No valid: stay in IDLE.
- FSM ACCESS (exactly 1 cycle):
  - ram_addr = latched addr, ram_data_in = latched wdata.
  - Read: ram_read=1; ram_data_out captured into rdata_q at the closing edge.
  - Write: ram_write=1, and the RAM commits at the closing edge.
  - Go to RESP.
- FSM RESP (1 cycle):
  - rsp{id}_valid=1.
  - rsp{id}_rdata = rdata_q for reads, 0 for writes.
  - Go to IDLE.
- ram_write and ram_read are 0 in every state except ACCESS. The two are never both 1.
- Latency:
  - Handshake at edge N; RAM access during cycle N+1; rsp_valid high during cycle N+2.
  - A new handshake is possible in cycle N+3, so peak throughput is 1 transaction per 3 cycles.
- Requesters hold valid, we, addr and wdata stable until ready. The arbiter ignores input changes outside IDLE.
- rspN_rdata holds its last value after the pulse, until the next response to that requester.
- Starvation-free: with both requesters continuously valid, grants alternate 0,1,0,1,...
- Reset mid-operation (rst_n low in ACCESS or RESP):
  - immediate return to IDLE, outputs cleared;
  - the in-flight transaction gets no response;
  - a write in ACCESS that has not yet reached the clock edge is not committed.
- Address wraps naturally within ADDR_W bits; there is no range checking except the optional feature.

Optional Feature:
- Macro: RAM_ARB_REGBANK_PROTECT_EN.
- Defined:
  - Writes from requester 1 to addresses 60..63 (register bank A/B/C/D) are suppressed: ram_write stays 0 in ACCESS.
  - The response is still issued, with rsp1_err=1 for that pulse.
  - Reads are unaffected. Requester 0 is never protected.
- Undefined: all writes proceed, and rsp1_err is tied 0.

Decomposition:
- Package ram_arb_pkg holds:
  - the state enum {IDLE, ACCESS, RESP};
  - ADDR_W/DATA_W defaults;
  - REGBANK_BASE = 6'd60;
  - requester id type (1 bit).
- Sub-module rr_arbiter2: combinational 2-way round-robin grant from (valid0, valid1, last_grant) to one-hot grant. It is instantiated once.

Test Plan:
- Reset check: rst_n low with random inputs -> all outputs 0; after release both valid -> req0_ready=1 first.
- Write then read: req0 write addr 5 data 0xBEEF -> ram_write=1 in ACCESS, rsp0_valid 2 cycles after handshake. Then req0 read addr 5 -> rsp0_rdata=0xBEEF, rsp0_valid pulse exactly 1 cycle.
- Contention: both valid continuously for 6 transactions -> grant order 0,1,0,1,0,1, each 3 cycles apart; ram_read and ram_write never both 1.
- Reset mid-operation: assert rst_n during ACCESS of a req1 write to addr 10 (0x1234) -> no rsp1_valid; a subsequent read of addr 10 returns its old value.
- Protect enabled (RAM_ARB_REGBANK_PROTECT_EN): req1 write addr 63 data 0x00FF -> ram_write=0, rsp1_err=1. Read addr 63 returns the prior value, and a req0 write to 63 succeeds. Without the macro, the same req1 write succeeds and rsp1_err=0.
- Single requester back-to-back: req1 held valid reading addr 0..3 -> accepted every 3rd cycle, correct data, req0_ready never asserted.
